// File: rtl/prbs_test_ctrl_if.sv
// Control/status bundle between the PRBS test sequencer and its user/LED/PRBS neighbours.
// The slave side is the sequencer; the master side drives start/stop/PRBS_error.
interface prbs_test_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             PRBS_error;
    logic             gen_en;
    logic             chk_load;
    logic             blinker;
    logic             locked;
    logic             lock_led;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;
    logic             sync_fail;

    modport master (
        output start, stop, PRBS_error,
        input  gen_en, chk_load, blinker, locked, lock_led, err_count, state, sync_fail
    );

    modport slave (
        input  start, stop, PRBS_error,
        output gen_en, chk_load, blinker, locked, lock_led, err_count, state, sync_fail
    );
endinterface

// File: rtl/prbs_test_ctrl.sv
// PRBS link test sequencer: IDLE -> SEED -> SYNC -> LOCKED with error counting and a free-running blinker.
// Optional SYNC timeout with sticky sync_fail is built when PRBS_CTRL_TIMEOUT_EN is defined.
module prbs_test_ctrl #(
    parameter int BLINK_DIV    = 25000000,
    parameter int SYNC_CYCLES  = 64,
    parameter int LOCK_LOSS    = 4,
    parameter int CNT_W        = 16,
    parameter int SYNC_TIMEOUT = 4096
) (
    input logic             clk,
    input logic             reset,
    prbs_test_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        SYNC   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int PW = $clog2(BLINK_DIV);
    localparam int RW = $clog2(SYNC_CYCLES + 1);
    localparam int BW = $clog2(LOCK_LOSS + 1);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(BLINK_DIV - 1);
    localparam logic [RW-1:0]    RUN_LAST   = RW'(SYNC_CYCLES - 1);
    localparam logic [BW-1:0]    BAD_LAST   = BW'(LOCK_LOSS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [RW-1:0]    run_q, run_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [PW-1:0]    presc_q;
    logic             blink_q;

`ifdef PRBS_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(SYNC_TIMEOUT - 1);
    logic [TW-1:0] to_q, to_d;
    logic          fail_q, fail_d;
`endif

    // Blinker prescaler is independent of the test state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            blink_q <= 1'b0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            blink_q <= ~blink_q;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            bad_q   <= '0;
            err_q   <= '0;
`ifdef PRBS_CTRL_TIMEOUT_EN
            to_q    <= '0;
            fail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
`ifdef PRBS_CTRL_TIMEOUT_EN
            to_q    <= to_d;
            fail_q  <= fail_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = '0;
        bad_d   = '0;
        err_d   = err_q;
`ifdef PRBS_CTRL_TIMEOUT_EN
        to_d    = '0;
        fail_d  = fail_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEED;
                    err_d   = '0;
`ifdef PRBS_CTRL_TIMEOUT_EN
                    fail_d  = 1'b0;
`endif
                end
            end
            SEED: state_d = SYNC;
            SYNC: begin
                if (bus.PRBS_error) begin
                    run_d = '0;
                end else if (run_q == RUN_LAST) begin
                    state_d = LOCKED;
                end else begin
                    run_d = run_q + 1'b1;
                end
`ifdef PRBS_CTRL_TIMEOUT_EN
                // Lock on the final timeout cycle still wins over the timeout.
                to_d = to_q + 1'b1;
                if (state_d == SYNC && to_q == TO_LAST) begin
                    state_d = IDLE;
                    run_d   = '0;
                    to_d    = '0;
                    fail_d  = 1'b1;
                end
`endif
            end
            LOCKED: begin
                if (bus.PRBS_error) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (bad_q == BAD_LAST) state_d = SEED;
                    else                   bad_d = bad_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.stop && state_q != IDLE) begin
            state_d = IDLE;
            run_d   = '0;
            bad_d   = '0;
`ifdef PRBS_CTRL_TIMEOUT_EN
            to_d    = '0;
            fail_d  = fail_q;
`endif
        end
    end

    assign bus.gen_en    = (state_q != IDLE);
    assign bus.chk_load  = (state_q == SEED);
    assign bus.locked    = (state_q == LOCKED);
    assign bus.lock_led  = (state_q == LOCKED) | ((state_q != IDLE) & blink_q);
    assign bus.blinker   = blink_q;
    assign bus.err_count = err_q;
    assign bus.state     = state_q;
`ifdef PRBS_CTRL_TIMEOUT_EN
    assign bus.sync_fail = fail_q;
`else
    assign bus.sync_fail = 1'b0;
`endif
endmodule
